dlfloat_add_sched: RTL and testbench

Round-robin scheduler that shares one registered DLFloat16 adder (`dlfloat_adder`, 1 sign / 6 exponent / 9 mantissa bits) between `N_REQ` independent requesters.
- Accepts one operand pair at a time over valid/ready, holds the operands on the adder inputs, and waits the adder latency.
- Captures the sum and returns it to the winning requester, tagged with its index.
- Sits between the vector-lane front ends and the single adder instance in the DL-float datapath.

---
 rtl/dlfloat_pkg.sv | 17 +
 rtl/dlfloat_rr_arbiter.sv | 32 +++
 rtl/dlfloat_add_sched.sv | 118 +++++++++++
 tb/tb_dlfloat_add_sched.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 types and constants for the DL-float datapath blocks.
// Format is 1 sign / 6 exponent / 9 mantissa bits.
package dlfloat_pkg;

   typedef logic [15:0] dlfloat16_t;

   localparam int EXP_W = 6;
   localparam int MAN_W = 9;
   localparam int BIAS  = 31;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } sched_state_t;

endpackage

// File: rtl/dlfloat_rr_arbiter.sv
// Combinational round-robin arbiter: the first valid request at or above ptr_i
// wins, wrapping at N_REQ-1. Produces a one-hot grant plus the encoded index.
module dlfloat_rr_arbiter #(
   parameter int N_REQ = 4,
   parameter int ID_W  = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [ID_W-1:0]  ptr_i,
   output logic [N_REQ-1:0] grant_o,
   output logic [ID_W-1:0]  idx_o,
   output logic             any_o
);

   always_comb begin
      int   j;
      logic found;
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(ptr_i) + k) % N_REQ;
         if (!found && req_i[j]) begin
            found      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = ID_W'(j);
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/dlfloat_add_sched.sv
// Round-robin scheduler sharing one registered DLFloat16 adder between N_REQ
// requesters: issue operands, wait the adder latency, return the tagged sum.
module dlfloat_add_sched
   import dlfloat_pkg::*;
#(
   parameter int N_REQ     = 4,
   parameter int ADDER_LAT = 1,
   parameter int ID_W      = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [16*N_REQ-1:0]  req_a,
   input  logic [16*N_REQ-1:0]  req_b,
   output logic [15:0]          add_a,
   output logic [15:0]          add_b,
   input  logic [15:0]          add_c,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [ID_W-1:0]      resp_id,
   output logic [15:0]          resp_data,
   output logic                 busy
);

   localparam int CNT_W = 3;

   sched_state_t    state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0] resp_id_q, resp_id_d;
   logic [CNT_W-1:0] lat_cnt_q, lat_cnt_d;
   dlfloat16_t      add_a_q, add_a_d;
   dlfloat16_t      add_b_q, add_b_d;
   dlfloat16_t      resp_data_q, resp_data_d;

   logic [N_REQ-1:0] gnt;
   logic [ID_W-1:0]  gnt_idx;
   logic             gnt_any;
   logic [N_REQ-1:0] ready_c;

   dlfloat_rr_arbiter #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_arb (
      .req_i   (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (gnt),
      .idx_o   (gnt_idx),
      .any_o   (gnt_any)
   );

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      resp_id_d   = resp_id_q;
      lat_cnt_d   = lat_cnt_q;
      add_a_d     = add_a_q;
      add_b_d     = add_b_q;
      resp_data_d = resp_data_q;
      ready_c     = '0;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               ready_c   = gnt;
               add_a_d   = req_a[16*gnt_idx +: 16];
               add_b_d   = req_b[16*gnt_idx +: 16];
               resp_id_d = gnt_idx;
               lat_cnt_d = CNT_W'(ADDER_LAT);
               rr_ptr_d  = (gnt_idx == ID_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
               state_d   = WAIT;
            end
         end
         WAIT: begin
            // Operands stay on the adder, so add_c is settled once the count expires.
            if (lat_cnt_q != '0) begin
               lat_cnt_d = lat_cnt_q - 1'b1;
            end else begin
               resp_data_d = add_c;
               state_d     = RESP;
            end
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         resp_id_q   <= '0;
         lat_cnt_q   <= '0;
         add_a_q     <= '0;
         add_b_q     <= '0;
         resp_data_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         resp_id_q   <= resp_id_d;
         lat_cnt_q   <= lat_cnt_d;
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         resp_data_q <= resp_data_d;
      end
   end

   // The state register reads IDLE during reset; keep the grant quiet until release.
   assign req_ready  = rst_n ? ready_c : '0;
   assign add_a      = add_a_q;
   assign add_b      = add_b_q;
   assign resp_id    = resp_id_q;
   assign resp_data  = resp_data_q;
   assign resp_valid = (state_q == RESP);
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dlfloat_add_sched.sv
// Self-checking bench for dlfloat_add_sched: fixed vectors, reset and
// round-robin corner sequences, then randomized traffic against a reference model.
module tb_dlfloat_add_sched;

   localparam int N   = 4;
   localparam int LAT = 1;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [16*N-1:0] req_a, req_b;
   logic [15:0]   add_a, add_b, add_c;
   logic          resp_valid, resp_ready;
   logic [1:0]    resp_id;
   logic [15:0]   resp_data;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;
   int ptr_m   = 0;

   always #5 clk = ~clk;

   dlfloat_add_sched #(.N_REQ(N), .ADDER_LAT(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b),
      .add_a(add_a), .add_b(add_b), .add_c(add_c),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_data(resp_data), .busy(busy)
   );

   // Stand-in for the external adder: exact doubling when a == b (zero and
   // all-ones exponent pass through), otherwise a deterministic scramble.
   function automatic logic [15:0] fake_add(input logic [15:0] a, input logic [15:0] b);
      if (a == b) begin
         if (a[14:0] == 15'd0)   return a;
         if (a[14:9] == 6'h3F)   return a;
         return a + 16'h0200;
      end
      return (a ^ {b[6:0], b[15:7]}) + 16'h0001;
   endfunction

   logic [15:0] c_pipe [LAT];
   always @(posedge clk) begin
      c_pipe[0] <= fake_add(add_a, add_b);
      for (int k = 1; k < LAT; k++) c_pipe[k] <= c_pipe[k-1];
   end
   assign add_c = c_pipe[LAT-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference arbitration: first valid index at or above the pointer, wrapping.
   function automatic int pick(input logic [N-1:0] mask, input int ptr);
      for (int k = 0; k < N; k++)
         if (mask[(ptr + k) % N]) return (ptr + k) % N;
      return -1;
   endfunction

   // Called at posedge+1 with the DUT idle. Keeps req_valid = mask throughout.
   task automatic run_txn(input logic [N-1:0] mask, input logic [16*N-1:0] av,
                          input logic [16*N-1:0] bv, input int hold,
                          output int gid, output logic [15:0] dout);
      int w, n;
      logic [15:0] exp_d;
      req_valid = mask; req_a = av; req_b = bv;
      #1;
      w = pick(mask, ptr_m);
      check("grant", {28'd0, req_ready}, 32'(1 << w));
      exp_d = fake_add(av[16*w +: 16], bv[16*w +: 16]);
      @(posedge clk); #1;
      ptr_m = (w + 1) % N;
      n = 0;
      while (!resp_valid && n < 20) begin
         check("ready_low_wait", {28'd0, req_ready}, 32'd0);
         @(posedge clk); #1;
         n++;
      end
      check("latency", n, LAT + 1);
      check("resp_id", resp_id, w);
      check("resp_data", resp_data, exp_d);
      resp_ready = 1'b0;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("hold_valid", resp_valid, 1);
         check("hold_id", resp_id, w);
         check("hold_data", resp_data, exp_d);
         check("hold_ready", {28'd0, req_ready}, 32'd0);
      end
      gid  = resp_id;
      dout = resp_data;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("busy_after_accept", busy, 0);
      check("valid_after_accept", resp_valid, 0);
   endtask

   typedef struct {
      logic [N-1:0] mask;
      logic [15:0]  a;
      logic [15:0]  b;
      int           hold;
      int           exp_id;
      logic [15:0]  exp_data;
   } vec_t;

   vec_t tbl [9];

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int gid;
      logic [15:0] d;

      tbl[0] = '{4'b1111, 16'h3E00, 16'h3E00, 0,  0, 16'h4000};
      tbl[1] = '{4'b1111, 16'h3E00, 16'h3E00, 0,  1, 16'h4000};
      tbl[2] = '{4'b1111, 16'h3E00, 16'h3E00, 0,  2, 16'h4000};
      tbl[3] = '{4'b1111, 16'h3E00, 16'h3E00, 0,  3, 16'h4000};
      tbl[4] = '{4'b1111, 16'h3E00, 16'h3E00, 0,  0, 16'h4000};
      tbl[5] = '{4'b0100, 16'hFFFF, 16'hFFFF, 10, 2, 16'hFFFF};
      tbl[6] = '{4'b1010, 16'h1234, 16'h1234, 2,  3, 16'h1434};
      tbl[7] = '{4'b1010, 16'h0000, 16'h0000, 0,  1, 16'h0000};
      tbl[8] = '{4'b0011, 16'h7BFF, 16'h7BFF, 1,  0, 16'h7DFF};

      rst_n = 1'b0; req_valid = '1; req_a = '0; req_b = '0; resp_ready = 1'b0;
      #3;
      check("rst_ready", {28'd0, req_ready}, 32'd0);
      check("rst_busy", busy, 0);
      check("rst_valid", resp_valid, 0);
      check("rst_ops", {add_a, add_b}, 32'd0);
      check("rst_resp", {14'd0, resp_id, resp_data}, 32'd0);
      req_valid = '0;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (tbl[i]) begin
         run_txn(tbl[i].mask, {N{tbl[i].a}}, {N{tbl[i].b}}, tbl[i].hold, gid, d);
         check($sformatf("vec%0d_id", i), gid, tbl[i].exp_id);
         check($sformatf("vec%0d_data", i), d, tbl[i].exp_data);
      end

      // Reset while the adder result is pending: nothing comes back, pointer clears.
      req_valid = 4'b0100; req_a = {N{16'h5555}}; req_b = {N{16'h1111}};
      @(posedge clk); #1;
      check("mid_busy", busy, 1);
      req_valid = '1;
      rst_n = 1'b0;
      #1;
      check("mid_rst_ops", {add_a, add_b}, 32'd0);
      check("mid_rst_resp", {13'd0, resp_valid, resp_id, resp_data}, 32'd0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_ready", {28'd0, req_ready}, 32'd0);
      req_valid = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      ptr_m = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         check("post_rst_quiet", {resp_valid, busy}, 32'd0);
      end
      run_txn(4'b1111, {N{16'h3E00}}, {N{16'h3E00}}, 0, gid, d);
      check("post_rst_first_id", gid, 0);

      // Randomized traffic against the reference arbitration and adder model.
      for (int t = 0; t < 40; t++) begin
         logic [N-1:0]    m;
         logic [16*N-1:0] av, bv;
         m  = N'($urandom_range(1, (1 << N) - 1));
         av = {$urandom, $urandom};
         bv = {$urandom, $urandom};
         run_txn(m, av, bv, $urandom_range(0, 3), gid, d);
      end

      req_valid = '0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
